dmem_responder: RTL and testbench

- Responder end of the data-memory request/response interface; the memory stage is the initiator.
- Holds the data array and accepts one load or store request per cycle from the barrel pipeline.
- Performs RISC-V byte/half/word sizing and sign/zero extension.
- Returns exactly one tagged response per request, carrying tid and rd, to the writeback side through a valid/ready handshake with back-pressure.

---
 rtl/dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word array with RISC-V byte/half/word sizing and a single
// tagged response register. Define DMEM_FAULT_CHECK_EN to enable access-fault detection.
module dmem_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DMEM_SIZE     = 64,
  parameter int NUM_THREADS   = 8,
  localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [BITS_THREADS-1:0]  req_tid,
  input  logic [4:0]               req_rd,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [BITS_THREADS-1:0]  rsp_tid,
  output logic [4:0]               rsp_rd,
  output logic                     rsp_we,
  output logic                     rsp_err
);

  localparam int IDX_W   = (DMEM_SIZE > 1) ? $clog2(DMEM_SIZE) : 1;
  localparam int WORD_AW = ADDRESS_WIDTH - 2;
  localparam int LANES   = DATA_WIDTH / 8;
  localparam logic [WORD_AW-1:0] DMEM_WORDS = WORD_AW'(DMEM_SIZE);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [0:0]              state_q, state_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [BITS_THREADS-1:0] rsp_tid_q, rsp_tid_d;
  logic [4:0]              rsp_rd_q, rsp_rd_d;
  logic                    rsp_we_q, rsp_we_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0]   mem_q [DMEM_SIZE];

  logic                    accept;
  logic                    funct3_legal;
  logic [2:0]              eff_funct3;
  logic [1:0]              size;
  logic                    is_unsigned;
  logic [WORD_AW-1:0]      word_addr;
  logic [IDX_W-1:0]        word_idx;
  logic                    fault;

  logic                    mem_we;
  logic [LANES-1:0]        mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [DATA_WIDTH-1:0]   load_data;

  // Handshake: a held response blocks new requests unless it drains this cycle.
  always_comb begin
    rsp_valid = (state_q == ST_FULL);
    req_ready = !rst && (!rsp_valid || rsp_ready);
    accept    = req_valid && req_ready;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    funct3_legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !req_we;
      default:          funct3_legal = 1'b0;
    endcase
  end

  assign word_addr = req_addr[ADDRESS_WIDTH-1:2];

`ifdef DMEM_FAULT_CHECK_EN
  logic out_of_range;
  logic misaligned;

  // Comparing the word address against the word count avoids overflowing DMEM_SIZE*4.
  always_comb begin
    eff_funct3   = req_funct3;
    size         = eff_funct3[1:0];
    is_unsigned  = eff_funct3[2];
    out_of_range = (word_addr >= DMEM_WORDS);
    misaligned   = ((size == SZ_HALF) && req_addr[0]) ||
                   ((size == 2'b10) && (req_addr[1:0] != 2'b00));
    fault        = out_of_range || misaligned || !funct3_legal;
    word_idx     = word_addr[IDX_W-1:0];
  end
`else
  // Without fault checking, illegal encodings fall back to a full-word access and
  // the index wraps around the array.
  always_comb begin
    eff_funct3  = funct3_legal ? req_funct3 : F3_W;
    size        = eff_funct3[1:0];
    is_unsigned = eff_funct3[2];
    fault       = 1'b0;
    word_idx    = IDX_W'(word_addr % DMEM_WORDS);
  end
`endif

  always_comb begin
    rd_word   = mem_q[word_idx];
    rd_byte   = rd_word[{req_addr[1:0], 3'b000} +: 8];
    rd_half   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    mem_be    = '0;
    mem_wdata = '0;
    load_data = '0;
    case (size)
      SZ_BYTE: begin
        mem_be    = LANES'(1) << req_addr[1:0];
        mem_wdata = {LANES{req_wdata[7:0]}};
        load_data = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, rd_byte}
                                : {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        mem_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{req_wdata[15:0]}};
        load_data = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, rd_half}
                                : {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
      end
      default: begin
        mem_be    = '1;
        mem_wdata = req_wdata;
        load_data = rd_word;
      end
    endcase
    mem_we = accept && req_we && !fault;
  end

  // NOTE: the data array is deliberately not reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we && mem_be[i]) begin
        mem_q[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // A new accept always wins over a drain, so the register is overwritten in place.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_tid_d   = rsp_tid_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      state_d     = ST_FULL;
      rsp_rdata_d = (req_we || fault) ? '0 : load_data;
      rsp_tid_d   = req_tid;
      rsp_rd_d    = req_rd;
      rsp_we_d    = req_we;
      rsp_err_d   = fault;
    end else if (rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      rsp_rdata_q <= '0;
      rsp_tid_q   <= '0;
      rsp_rd_q    <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_tid   = rsp_tid_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: sizing, ordering, back-pressure, faults/wrap, reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_tid;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_tid;
  logic [4:0]  rsp_rd;
  logic        rsp_we;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_tid    (req_tid),
    .req_rd     (req_rd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_tid    (rsp_tid),
    .rsp_rd     (rsp_rd),
    .rsp_we     (rsp_we),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present one request and return 1 time unit after the edge that accepts it.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] tid, input logic [4:0] rd);
    int n = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_tid    = tid;
    req_rd     = rd;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic [2:0] tid,
                            input logic [4:0] rd, input logic we, input logic err);
    check({tag, ".valid"}, rsp_valid, 1'b1);
    check({tag, ".rdata"}, rsp_rdata, rdata);
    check({tag, ".tid"},   rsp_tid, tid);
    check({tag, ".rd"},    rsp_rd, rd);
    check({tag, ".we"},    rsp_we, we);
    check({tag, ".err"},   rsp_err, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    req_tid = '0; req_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", req_ready, 1'b0);
    check("rst.valid", rsp_valid, 1'b0);
    check("rst.rdata", rsp_rdata, 32'h0);
    check("rst.tid", rsp_tid, 3'd0);
    check("rst.rd", rsp_rd, 5'd0);
    check("rst.we", rsp_we, 1'b0);
    check("rst.err", rsp_err, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Store then back-to-back load of the same word.
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 3'd3, 5'd5);
    expect_rsp("sw_10", 32'h0, 3'd3, 5'd5, 1'b1, 1'b0);
    send(1'b0, 3'b010, 32'h10, 32'h0, 3'd1, 5'd7);
    expect_rsp("lw_10", 32'hDEADBEEF, 3'd1, 5'd7, 1'b0, 1'b0);

    // Sizing and extension.
    send(1'b0, 3'b000, 32'h13, 32'h0, 3'd2, 5'd1);
    expect_rsp("lb_13", 32'hFFFFFFDE, 3'd2, 5'd1, 1'b0, 1'b0);
    send(1'b0, 3'b100, 32'h13, 32'h0, 3'd2, 5'd2);
    expect_rsp("lbu_13", 32'h000000DE, 3'd2, 5'd2, 1'b0, 1'b0);
    send(1'b0, 3'b001, 32'h10, 32'h0, 3'd2, 5'd3);
    expect_rsp("lh_10", 32'hFFFFBEEF, 3'd2, 5'd3, 1'b0, 1'b0);
    send(1'b0, 3'b101, 32'h12, 32'h0, 3'd2, 5'd4);
    expect_rsp("lhu_12", 32'h0000DEAD, 3'd2, 5'd4, 1'b0, 1'b0);

    // Byte store touches only its lane.
    send(1'b1, 3'b000, 32'h11, 32'hAAAAAA55, 3'd5, 5'd6);
    expect_rsp("sb_11", 32'h0, 3'd5, 5'd6, 1'b1, 1'b0);
    send(1'b0, 3'b010, 32'h10, 32'h0, 3'd5, 5'd8);
    expect_rsp("lw_after_sb", 32'hDEAD55EF, 3'd5, 5'd8, 1'b0, 1'b0);

    // Boundary word and base word used by the range tests.
    send(1'b1, 3'b010, 32'hFC, 32'h0BADCAFE, 3'd0, 5'd9);
    send(1'b0, 3'b010, 32'hFC, 32'h0, 3'd0, 5'd10);
    expect_rsp("lw_fc", 32'h0BADCAFE, 3'd0, 5'd10, 1'b0, 1'b0);
    send(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 3'd0, 5'd11);

    // Back-pressure: a held response blocks a pending request, then both move on one edge.
    send(1'b0, 3'b010, 32'h10, 32'h0, 3'd2, 5'd9);
    rsp_ready = 1'b0;
    expect_rsp("bp_load", 32'hDEAD55EF, 3'd2, 5'd9, 1'b0, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h10;
    req_tid = 3'd4; req_rd = 5'd10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.req_ready", req_ready, 1'b0);
      check("bp.valid", rsp_valid, 1'b1);
      check("bp.rdata", rsp_rdata, 32'hDEAD55EF);
      check("bp.tid", rsp_tid, 3'd2);
      check("bp.rd", rsp_rd, 5'd9);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp.ready_release", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    expect_rsp("bp_new", 32'h000000EF, 3'd4, 5'd10, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp.drained", rsp_valid, 1'b0);

`ifdef DMEM_FAULT_CHECK_EN
    send(1'b0, 3'b010, 32'h12, 32'h0, 3'd6, 5'd12);
    expect_rsp("f_lw_mis", 32'h0, 3'd6, 5'd12, 1'b0, 1'b1);
    send(1'b0, 3'b001, 32'h11, 32'h0, 3'd6, 5'd13);
    expect_rsp("f_lh_mis", 32'h0, 3'd6, 5'd13, 1'b0, 1'b1);
    send(1'b1, 3'b010, 32'h100, 32'h11111111, 3'd6, 5'd14);
    expect_rsp("f_sw_oor", 32'h0, 3'd6, 5'd14, 1'b1, 1'b1);
    send(1'b0, 3'b010, 32'h0, 32'h0, 3'd6, 5'd15);
    expect_rsp("f_lw_0", 32'hCAFEF00D, 3'd6, 5'd15, 1'b0, 1'b0);
    send(1'b0, 3'b011, 32'h10, 32'h0, 3'd6, 5'd16);
    expect_rsp("f_f3_011", 32'h0, 3'd6, 5'd16, 1'b0, 1'b1);
`else
    send(1'b0, 3'b010, 32'h12, 32'h0, 3'd6, 5'd12);
    expect_rsp("w_lw_12", 32'hDEAD55EF, 3'd6, 5'd12, 1'b0, 1'b0);
    send(1'b0, 3'b001, 32'h11, 32'h0, 3'd6, 5'd13);
    expect_rsp("w_lh_11", 32'h000055EF, 3'd6, 5'd13, 1'b0, 1'b0);
    send(1'b1, 3'b010, 32'h100, 32'h11111111, 3'd6, 5'd14);
    expect_rsp("w_sw_100", 32'h0, 3'd6, 5'd14, 1'b1, 1'b0);
    send(1'b0, 3'b010, 32'h0, 32'h0, 3'd6, 5'd15);
    expect_rsp("w_lw_0", 32'h11111111, 3'd6, 5'd15, 1'b0, 1'b0);
    send(1'b0, 3'b011, 32'h10, 32'h0, 3'd6, 5'd16);
    expect_rsp("w_f3_011", 32'hDEAD55EF, 3'd6, 5'd16, 1'b0, 1'b0);
`endif

    // Reset while a response is stalled; a store presented during reset must be ignored.
    send(1'b0, 3'b010, 32'h10, 32'h0, 3'd6, 5'd20);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("rstmid.valid_before", rsp_valid, 1'b1);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
    req_wdata = 32'h0; req_tid = 3'd1; req_rd = 5'd1;
    #1;
    check("rstmid.req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    check("rstmid.valid", rsp_valid, 1'b0);
    check("rstmid.rdata", rsp_rdata, 32'h0);
    check("rstmid.tid", rsp_tid, 3'd0);
    check("rstmid.rd", rsp_rd, 5'd0);
    check("rstmid.we", rsp_we, 1'b0);
    check("rstmid.err", rsp_err, 1'b0);
    rst = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rstmid.idle", rsp_valid, 1'b0);
    send(1'b0, 3'b010, 32'h10, 32'h0, 3'd7, 5'd31);
    expect_rsp("post_rst_lw", 32'hDEAD55EF, 3'd7, 5'd31, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
